serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 4 +
 rtl/serial_adder_add_digit.sv | 21 ++
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding shared by the serial adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/serial_adder_add_digit.sv
// add_digit: DIGIT-wide ripple-carry adder built from full-adder cells,
// also exposing the carry into the MSB for signed-overflow detection.
module add_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [DIGIT:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, DIGIT bits per clock, LSB slice first.
// Subtraction latches ~b with carry-in 1, so cout=1 means no borrow.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIGIT-1:0] dsum;
    logic             dco, dcm;

    add_digit #(.DIGIT(DIGIT)) u_add (
        .a   (a_q[DIGIT*int'(cnt_q) +: DIGIT]),
        .b   (b_q[DIGIT*int'(cnt_q) +: DIGIT]),
        .cin (carry_q),
        .sum (dsum),
        .cout(dco),
        .cmsb(dcm)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? RUN : IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sum_d[DIGIT*int'(cnt_q) +: DIGIT] = dsum;
                carry_d = dco;
                // counter wraps to 0 on the last slice so it never indexes past the operands
                cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = dco;
                    ovf_d   = dcm ^ dco;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder at WIDTH=8
// for DIGIT in {1,2,4,8}; index k selects DIGIT = 1<<k, N = 8>>k.
module tb_serial_adder;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            sub = 1'b0;
    logic [7:0]      a = '0;
    logic [7:0]      b = '0;
    logic [3:0]      busy_w, done_w, cout_w, ovf_w;
    logic [3:0][7:0] sum_w;
    int              vectors = 0;
    int              miscompares = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        serial_adder #(.WIDTH(8), .DIGIT(1 << k)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start),
            .sub  (sub),
            .a    (a),
            .b    (b),
            .busy (busy_w[k]),
            .done (done_w[k]),
            .sum  (sum_w[k]),
            .cout (cout_w[k]),
            .ovf  (ovf_w[k])
        );
    end

    // Reference: {cout, ovf, sum} from plain integer arithmetic on the operands.
    function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        int sa = $signed(av);
        int sb = $signed(bv);
        int r  = sv ? sa - sb : sa + sb;
        int u  = sv ? int'(av) - int'(bv) : int'(av) + int'(bv);
        logic c = sv ? (av >= bv) : (u > 255);
        logic o = (r > 127) || (r < -128);
        return {c, o, u[7:0]};
    endfunction

    task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic sv, input int k, output int lat);
        a = av;
        b = bv;
        sub = sv;
        start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end while (!done_w[k] && lat < 20);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int lat;
        #1;
        vectors++;
        if ({busy_w, done_w, cout_w, ovf_w} !== 16'h0 || sum_w !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b cout=%b ovf=%b sum=%h, required all zero", busy_w, done_w, cout_w, ovf_w, sum_w);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op(8'h21, 8'h13, 1'b0, 1, lat);
        vectors++;
        if (lat !== 5 || sum_w[1] !== 8'h34) begin
            miscompares++;
            $display("FAIL first_start: lat=%0d sum=%h, required lat=5 sum=34", lat, sum_w[1]);
        end
    endtask

    task automatic test_add_ovf();
        int lat;
        op(8'h7F, 8'h01, 1'b0, 1, lat);
        vectors++;
        if (lat !== 5 || sum_w[1] !== 8'h80 || cout_w[1] !== 1'b0 || ovf_w[1] !== 1'b1 || busy_w[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL add_ovf: lat=%0d sum=%h cout=%b ovf=%b busy=%b, required 5 80 0 1 0", lat, sum_w[1], cout_w[1], ovf_w[1], busy_w[1]);
        end
    endtask

    task automatic test_sub();
        int lat;
        idle(1);
        op(8'h05, 8'h07, 1'b1, 1, lat);
        vectors++;
        if (lat !== 5 || sum_w[1] !== 8'hFE || cout_w[1] !== 1'b0 || ovf_w[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_borrow: lat=%0d sum=%h cout=%b ovf=%b, required 5 fe 0 0", lat, sum_w[1], cout_w[1], ovf_w[1]);
        end
        idle(1);
        op(8'h80, 8'h01, 1'b1, 1, lat);
        vectors++;
        if (lat !== 5 || sum_w[1] !== 8'h7F || cout_w[1] !== 1'b1 || ovf_w[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_ovf: lat=%0d sum=%h cout=%b ovf=%b, required 5 7f 1 1", lat, sum_w[1], cout_w[1], ovf_w[1]);
        end
    endtask

    task automatic test_ignore_start();
        int lat = 1;
        idle(1);
        a = 8'hFF;
        b = 8'h01;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h11;
        b = 8'h11;
        sub = 1'b1;
        vectors++;
        if (busy_w[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_run: busy=%b, required 1", busy_w[1]);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 2;
        while (!done_w[1] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== 5 || sum_w[1] !== 8'h00 || cout_w[1] !== 1'b1 || ovf_w[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start: lat=%0d sum=%h cout=%b ovf=%b, required 5 00 1 0", lat, sum_w[1], cout_w[1], ovf_w[1]);
        end
        idle(1);
        vectors++;
        if (done_w[1] !== 1'b0 || busy_w[1] !== 1'b0 || sum_w[1] !== 8'h00 || cout_w[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_after_done: done=%b busy=%b sum=%h cout=%b, required 0 0 00 1", done_w[1], busy_w[1], sum_w[1], cout_w[1]);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        op(8'h03, 8'h04, 1'b0, 1, lat);
        vectors++;
        if (lat !== 5 || sum_w[1] !== 8'h07) begin
            miscompares++;
            $display("FAIL b2b_first: lat=%0d sum=%h, required 5 07", lat, sum_w[1]);
        end
        a = 8'h10;
        b = 8'h20;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if (busy_w[1] !== 1'b1 || done_w[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_gap: busy=%b done=%b, required 1 0", busy_w[1], done_w[1]);
        end
        lat = 1;
        while (!done_w[1] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== 5 || sum_w[1] !== 8'h30) begin
            miscompares++;
            $display("FAIL b2b_second: lat=%0d sum=%h, required 5 30", lat, sum_w[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        idle(1);
        a = 8'h55;
        b = 8'h22;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy_w[1] !== 1'b0 || done_w[1] !== 1'b0 || sum_w[1] !== 8'h00 || cout_w[1] !== 1'b0 || ovf_w[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b ovf=%b, required all zero", busy_w[1], done_w[1], sum_w[1], cout_w[1], ovf_w[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (done_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL no_done_after_reset: cycle=%0d done=%b busy=%b, required 0 0", c, done_w[1], busy_w[1]);
            end
        end
        op(8'h01, 8'h02, 1'b0, 1, lat);
        vectors++;
        if (lat !== 5 || sum_w[1] !== 8'h03) begin
            miscompares++;
            $display("FAIL after_reset_op: lat=%0d sum=%h, required 5 03", lat, sum_w[1]);
        end
    endtask

    task automatic test_digit_eq_width();
        int lat;
        idle(12);
        op(8'h40, 8'h40, 1'b0, 3, lat);
        vectors++;
        if (lat !== 2 || sum_w[3] !== 8'h80 || ovf_w[3] !== 1'b1 || cout_w[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL digit_eq_width: lat=%0d sum=%h ovf=%b cout=%b, required 2 80 1 0", lat, sum_w[3], ovf_w[3], cout_w[3]);
        end
    endtask

    task automatic test_random();
        idle(12);
        for (int n = 0; n < 2000; n++) begin
            int          lat_r[4] = '{0, 0, 0, 0};
            logic [7:0]  av = 8'($urandom);
            logic [7:0]  bv = 8'($urandom);
            logic        sv = 1'($urandom);
            logic [9:0]  exp_r = model(av, bv, sv);
            a = av;
            b = bv;
            sub = sv;
            start = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                for (int k = 0; k < 4; k++)
                    if (done_w[k] && lat_r[k] == 0) lat_r[k] = c;
            end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (lat_r[k] !== (8 >> k) + 1 || {cout_w[k], ovf_w[k], sum_w[k]} !== exp_r) begin
                    miscompares++;
                    $display("FAIL random DIGIT=%0d a=%h b=%h sub=%b: lat=%0d cout=%b ovf=%b sum=%h, required lat=%0d cout=%b ovf=%b sum=%h",
                             1 << k, av, bv, sv, lat_r[k], cout_w[k], ovf_w[k], sum_w[k], (8 >> k) + 1, exp_r[9], exp_r[8], exp_r[7:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_digit_eq_width();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
